rr_burst_arbiter: RTL and testbench

- Registered round-robin arbiter with two priority classes; shares one downstream resource (bus or port) between NUM_MASTER requesters.
- A grant is held for a whole burst: until the granted master's last beat, a burst-length cap, or request withdrawal.
- Rotating pointer gives fairness within a class; the pri class always beats the normal class.

---
 rtl/rr_burst_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_rr_burst_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter with two priority classes: a grant is held until last beat, burst cap or request drop.
// Optional stall watchdog enabled by defining RR_ARB_WATCHDOG_EN.
module rr_burst_arbiter #(
    parameter int unsigned NUM_MASTER  = 4,
    parameter int unsigned MAX_BURST   = 16,
    parameter int unsigned WDOG_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_MASTER-1:0] req,
    input  logic [NUM_MASTER-1:0] pri,
    input  logic                  beat_valid,
    input  logic                  beat_last,
    output logic [NUM_MASTER-1:0] grant,
    output logic [((NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1)-1:0] grant_id,
    output logic                  busy,
    output logic                  wdog_err
);

    localparam int unsigned IDW  = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;
    localparam int unsigned CNTW = $clog2(MAX_BURST + 1);
    localparam int unsigned WDW  = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    // Elaboration-time parameter sanity checks
    if (NUM_MASTER < 2) begin : g_bad_num_master
        $error("rr_burst_arbiter: NUM_MASTER must be >= 2");
    end
    if (MAX_BURST < 1) begin : g_bad_max_burst
        $error("rr_burst_arbiter: MAX_BURST must be >= 1");
    end
    if (WDOG_CYCLES < 1) begin : g_bad_wdog
        $error("rr_burst_arbiter: WDOG_CYCLES must be >= 1");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NUM_MASTER-1:0] r_grant;
    logic [NUM_MASTER-1:0] w_grant_nxt;
    logic [IDW-1:0]        r_grant_id;
    logic [IDW-1:0]        w_grant_id_nxt;
    logic                  r_busy;
    logic                  w_busy_nxt;
    logic [IDW-1:0]        r_ptr;
    logic [IDW-1:0]        w_ptr_nxt;
    logic [CNTW-1:0]       r_beat_cnt;
    logic [CNTW-1:0]       w_beat_cnt_nxt;
    logic                  w_release;

    logic [NUM_MASTER-1:0] w_req_pri;
    logic [NUM_MASTER-1:0] w_cand;
    logic                  w_found;
    logic [IDW-1:0]        w_winner;
    int unsigned           w_idx;

`ifdef RR_ARB_WATCHDOG_EN
    logic [WDW-1:0]        r_wdog_cnt;
    logic [WDW-1:0]        w_wdog_cnt_nxt;
    logic                  r_wdog_err;
    logic                  w_wdog_err_nxt;
`endif

    // Candidate selection and rotating search upward from r_ptr+1
    always_comb begin
        w_req_pri = req & pri;
        w_cand    = (w_req_pri != '0) ? w_req_pri : req;
        w_found   = 1'b0;
        w_winner  = '0;
        w_idx     = 0;
        for (int unsigned k = 1; k <= NUM_MASTER; k++) begin
            w_idx = (32'(r_ptr) + k) % NUM_MASTER;
            if (!w_found && w_cand[IDW'(w_idx)]) begin
                w_found  = 1'b1;
                w_winner = IDW'(w_idx);
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_busy_nxt     = r_busy;
        w_ptr_nxt      = r_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        w_release      = 1'b0;
`ifdef RR_ARB_WATCHDOG_EN
        w_wdog_cnt_nxt = r_wdog_cnt;
        w_wdog_err_nxt = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt           = S_BUSY;
                    w_grant_nxt           = '0;
                    w_grant_nxt[w_winner] = 1'b1;
                    w_grant_id_nxt        = w_winner;
                    w_busy_nxt            = 1'b1;
                    w_ptr_nxt             = w_winner;
                    w_beat_cnt_nxt        = '0;
`ifdef RR_ARB_WATCHDOG_EN
                    w_wdog_cnt_nxt        = '0;
`endif
                end
            end
            S_BUSY: begin
                if (!req[r_grant_id]) begin
                    w_release = 1'b1;
                end else if (beat_valid && beat_last) begin
                    w_release = 1'b1;
                end else if (beat_valid && (r_beat_cnt == CNTW'(MAX_BURST - 1))) begin
                    w_release = 1'b1;
                end else if (beat_valid) begin
                    w_beat_cnt_nxt = r_beat_cnt + CNTW'(1);
`ifdef RR_ARB_WATCHDOG_EN
                end else if (r_wdog_cnt == WDW'(WDOG_CYCLES - 1)) begin
                    w_release      = 1'b1;
                    w_wdog_err_nxt = 1'b1;
`endif
                end
`ifdef RR_ARB_WATCHDOG_EN
                w_wdog_cnt_nxt = beat_valid ? '0 : (r_wdog_cnt + WDW'(1));
`endif
                if (w_release) begin
                    w_state_nxt    = S_IDLE;
                    w_grant_nxt    = '0;
                    w_grant_id_nxt = '0;
                    w_busy_nxt     = 1'b0;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_grant_nxt    = '0;
                w_grant_id_nxt = '0;
                w_busy_nxt     = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_ptr      <= IDW'(NUM_MASTER - 1);
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_busy     <= w_busy_nxt;
            r_ptr      <= w_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

`ifdef RR_ARB_WATCHDOG_EN
    // Stall counter and error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            r_wdog_cnt <= w_wdog_cnt_nxt;
            r_wdog_err <= w_wdog_err_nxt;
        end
    end

    assign wdog_err = r_wdog_err;
`else
    assign wdog_err = 1'b0;
`endif

    assign grant    = r_grant;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Testbench for rr_burst_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Watchdog scenarios follow RR_ARB_WATCHDOG_EN.
module tb_rr_burst_arbiter;

    localparam int unsigned NM = 4;
    localparam int unsigned MB = 16;
    localparam int unsigned WD = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [NM-1:0] req;
    logic [NM-1:0] pri;
    logic          beat_valid;
    logic          beat_last;
    logic [NM-1:0] grant;
    logic [1:0]    grant_id;
    logic          busy;
    logic          wdog_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: owner index (-1 idle), rotating pointer, beats taken, stall cycles
    int m_owner;
    int m_ptr;
    int m_beats;
    int m_stall;
    bit m_werr;

    rr_burst_arbiter #(
        .NUM_MASTER (NM),
        .MAX_BURST  (MB),
        .WDOG_CYCLES(WD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .pri       (pri),
        .beat_valid(beat_valid),
        .beat_last (beat_last),
        .grant     (grant),
        .grant_id  (grant_id),
        .busy      (busy),
        .wdog_err  (wdog_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = NM - 1;
        m_beats = 0;
        m_stall = 0;
        m_werr  = 1'b0;
    endtask

    task automatic model_step(input logic [NM-1:0] r, input logic [NM-1:0] p,
                              input logic bv, input logic bl);
        logic [NM-1:0] cand;
        bit            rel;
        m_werr = 1'b0;
        if (m_owner < 0) begin
            cand = ((r & p) != 0) ? (r & p) : r;
            for (int k = 1; k <= NM; k++) begin
                int idx;
                idx = (m_ptr + k) % NM;
                if (m_owner < 0 && cand[idx]) begin
                    m_owner = idx;
                    m_ptr   = idx;
                    m_beats = 0;
                    m_stall = 0;
                end
            end
        end else begin
            rel = 1'b0;
            if (!r[m_owner]) rel = 1'b1;
            else if (bv && bl) rel = 1'b1;
            else if (bv && m_beats == MB - 1) rel = 1'b1;
            else if (bv) m_beats++;
`ifdef RR_ARB_WATCHDOG_EN
            else if (m_stall == WD - 1) begin
                rel    = 1'b1;
                m_werr = 1'b1;
            end
`endif
            m_stall = bv ? 0 : m_stall + 1;
            if (rel) m_owner = -1;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_grant"},    32'(grant),    (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        check({tag, "_grant_id"}, 32'(grant_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check({tag, "_busy"},     32'(busy),     32'(m_owner >= 0));
        check({tag, "_wdog_err"}, 32'(wdog_err), 32'(m_werr));
    endtask

    task automatic cyc(input string tag, input logic [NM-1:0] r, input logic [NM-1:0] p,
                       input logic bv, input logic bl);
        req        = r;
        pri        = p;
        beat_valid = bv;
        beat_last  = bl;
        model_step(r, p, bv, bl);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_model("reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [NM-1:0] seq [9];
        logic [NM-1:0] rr;
        logic [NM-1:0] rp;
        rst        = 1'b0;
        req        = '0;
        pri        = '0;
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        do_reset();

        // Basic grant, last-beat release, dead cycle, rotation
        cyc("basic0", 4'b0101, 4'b0000, 1'b0, 1'b0);
        check("basic0_onehot", 32'(grant), 32'h1);
        cyc("basic1", 4'b0101, 4'b0000, 1'b1, 1'b1);
        check("basic1_dead", 32'(grant), 32'h0);
        cyc("basic2", 4'b0101, 4'b0000, 1'b0, 1'b0);
        check("basic2_next", 32'(grant), 32'h4);

        // Round-robin rotation with single-beat bursts
        do_reset();
        seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        for (int i = 0; i < 9; i++) begin
            cyc("rot", 4'b1111, 4'b0000, 1'b1, 1'b1);
            check("rot_seq", 32'(grant), 32'(seq[i]));
        end

        // Priority class beats pointer; no preemption mid-burst
        do_reset();
        cyc("pri0", 4'b0011, 4'b0010, 1'b0, 1'b0);
        check("pri0_win", 32'(grant), 32'h2);
        for (int i = 0; i < 3; i++) begin
            cyc("pri_hold", 4'b0011, 4'b0011, 1'b1, 1'b0);
            check("pri_hold_grant", 32'(grant), 32'h2);
        end
        cyc("pri_rel", 4'b0011, 4'b0011, 1'b1, 1'b1);
        cyc("pri_next", 4'b0011, 4'b0011, 1'b0, 1'b0);
        check("pri_next_grant", 32'(grant), 32'h1);

        // Burst cap releases after MB beats; cap-released master goes last
        do_reset();
        cyc("cap0", 4'b0100, 4'b0000, 1'b1, 1'b0);
        check("cap0_grant", 32'(grant), 32'h4);
        for (int i = 1; i <= MB; i++) begin
            cyc("cap_beat", 4'b0110, 4'b0000, 1'b1, 1'b0);
            check("cap_beat_grant", 32'(grant), (i == MB) ? 32'h0 : 32'h4);
        end
        cyc("cap_next", 4'b0110, 4'b0000, 1'b0, 1'b0);
        check("cap_next_grant", 32'(grant), 32'h2);

        // Request withdrawal aborts even with a beat present
        do_reset();
        cyc("abort0", 4'b1000, 4'b0000, 1'b0, 1'b0);
        check("abort0_id", 32'(grant_id), 32'd3);
        cyc("abort1", 4'b0000, 4'b0000, 1'b1, 1'b0);
        check("abort1_grant", 32'(grant), 32'h0);
        check("abort1_busy", 32'(busy), 32'h0);

        // Stalled burst: watchdog release or indefinite hold
        do_reset();
        cyc("wd_g", 4'b0001, 4'b0000, 1'b0, 1'b0);
`ifdef RR_ARB_WATCHDOG_EN
        for (int i = 1; i <= 63; i++) cyc("wd_stall", 4'b0001, 4'b0000, 1'b0, 1'b0);
        check("wd_hold63", 32'(grant), 32'h1);
        cyc("wd_fire", 4'b0001, 4'b0000, 1'b0, 1'b0);
        check("wd_fire_grant", 32'(grant), 32'h0);
        check("wd_fire_err", 32'(wdog_err), 32'h1);
        cyc("wd_regrant", 4'b0001, 4'b0000, 1'b0, 1'b0);
        check("wd_pulse_end", 32'(wdog_err), 32'h0);
        for (int i = 1; i <= 63; i++) cyc("wd_stall2", 4'b0001, 4'b0000, 1'b0, 1'b0);
        cyc("wd_beat63", 4'b0001, 4'b0000, 1'b1, 1'b0);
        check("wd_beat63_hold", 32'(grant), 32'h1);
        for (int i = 1; i <= 63; i++) cyc("wd_stall3", 4'b0001, 4'b0000, 1'b0, 1'b0);
        check("wd_restart_hold", 32'(grant), 32'h1);
        cyc("wd_fire2", 4'b0001, 4'b0000, 1'b0, 1'b0);
        check("wd_fire2_err", 32'(wdog_err), 32'h1);
`else
        for (int i = 0; i < 1000; i++) cyc("nowd_stall", 4'b0001, 4'b0000, 1'b0, 1'b0);
        check("nowd_hold_grant", 32'(grant), 32'h1);
        check("nowd_hold_busy", 32'(busy), 32'h1);
`endif

        // Randomized traffic with occasional asynchronous reset
        do_reset();
        rr = 4'b1111;
        rp = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) rr = 4'($urandom);
            if ($urandom_range(0, 7) == 0) rp = 4'($urandom) & 4'($urandom);
            cyc("rand", rr, rp, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 399) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
